// File: rtl/multi_control.sv
// rtl/multi_control.sv - multicycle MIPS main control FSM
// Optional ADDI support is compiled in when the ADDI_EN macro is defined.
module multi_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic        zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        pc_en,
  output logic [1:0]  PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMRD     = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWR     = 4'd6,
    S_EXEC      = 4'd7,
    S_RTYPE_WB  = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t      state_q;
  state_t      nxt_state;
  logic [31:0] cnt_q;

  // Opcodes the decoder dispatches on; anything else is flagged illegal.
  function automatic logic is_known(input logic [5:0] o);
    logic k;
    case (o)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: k = 1'b1;
`ifdef ADDI_EN
      OP_ADDI: k = 1'b1;
`endif
      default: k = 1'b0;
    endcase
    return k;
  endfunction

  // States whose exit retires an instruction.
  function automatic logic is_retire(input state_t s);
    logic r;
    case (s)
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BRANCH, S_JUMP: r = 1'b1;
`ifdef ADDI_EN
      S_ADDI_WB: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state selection; op is the IR-held opcode, stable after FETCH.
  always_comb begin
    nxt_state = S_IDLE;
    case (state_q)
      S_IDLE:   nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      nxt_state = S_ADDI_EXEC;
`endif
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR:    nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:     nxt_state = S_MEMWB;
      S_MEMWB:     nxt_state = S_FETCH;
      S_MEMWR:     nxt_state = S_FETCH;
      S_EXEC:      nxt_state = S_RTYPE_WB;
      S_RTYPE_WB:  nxt_state = S_FETCH;
      S_BRANCH:    nxt_state = S_FETCH;
      S_JUMP:      nxt_state = S_FETCH;
`ifdef ADDI_EN
      S_ADDI_EXEC: nxt_state = S_ADDI_WB;
      S_ADDI_WB:   nxt_state = S_FETCH;
`endif
      default:     nxt_state = S_IDLE;
    endcase
  end

  // State, retire counter and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    PCWrite     <= 1'b0;
    PCWriteCond <= 1'b0;
    PCSource    <= 2'b00;
    IorD        <= 1'b0;
    MemRead     <= 1'b0;
    MemWrite    <= 1'b0;
    IRWrite     <= 1'b0;
    MemtoReg    <= 1'b0;
    RegDst      <= 1'b0;
    RegWrite    <= 1'b0;
    ALUOp       <= 2'b00;
    ALUSrcA     <= 1'b0;
    ALUSrcB     <= 2'b00;
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= nxt_state;
      if (is_retire(state_q)) begin
        cnt_q <= cnt_q + 32'd1;
      end
      case (nxt_state)
        S_FETCH: begin
          MemRead <= 1'b1;
          IRWrite <= 1'b1;
          PCWrite <= 1'b1;
          ALUSrcB <= 2'b01;
        end
        S_DECODE: ALUSrcB <= 2'b11;
        S_MEMADR: begin
          ALUSrcA <= 1'b1;
          ALUSrcB <= 2'b10;
        end
        S_MEMRD: begin
          MemRead <= 1'b1;
          IorD    <= 1'b1;
        end
        S_MEMWB: begin
          RegWrite <= 1'b1;
          MemtoReg <= 1'b1;
        end
        S_MEMWR: begin
          MemWrite <= 1'b1;
          IorD     <= 1'b1;
        end
        S_EXEC: begin
          ALUSrcA <= 1'b1;
          ALUOp   <= 2'b10;
        end
        S_RTYPE_WB: begin
          RegWrite <= 1'b1;
          RegDst   <= 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     <= 1'b1;
          ALUOp       <= 2'b01;
          PCWriteCond <= 1'b1;
          PCSource    <= 2'b01;
        end
        S_JUMP: begin
          PCWrite  <= 1'b1;
          PCSource <= 2'b10;
        end
`ifdef ADDI_EN
        S_ADDI_EXEC: begin
          ALUSrcA <= 1'b1;
          ALUSrcB <= 2'b10;
        end
        S_ADDI_WB: RegWrite <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // The branch qualifier follows the live ALU zero flag.
  assign pc_en      = PCWrite | (PCWriteCond & zero);
  assign illegal_op = (state_q == S_DECODE) && !is_known(op);
  assign state      = state_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_multi_control.sv
// tb/tb_multi_control.sv - scoreboard bench for multi_control
module tb_multi_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic        zero;
  logic        PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  multi_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .illegal_op(illegal_op),
    .state(state), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] m_cnt;

  wire [17:0] obs_ctrl = {PCWrite, PCWriteCond, pc_en, PCSource, IorD, MemRead,
                          MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUOp,
                          ALUSrcA, ALUSrcB, illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic [5:0] o, input logic z);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, ill;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, ill} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (s)
      4'd1:  begin mr = 1; irw = 1; pcw = 1; srcb = 2'b01; end
      4'd2:  begin
        srcb = 2'b11;
        ill = !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                o == 6'b000100 || o == 6'b000010
`ifdef ADDI_EN
                || o == 6'b001000
`endif
               );
      end
      4'd3:  begin srca = 1; srcb = 2'b10; end
      4'd4:  begin mr = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mw = 1; iord = 1; end
      4'd7:  begin srca = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
`ifdef ADDI_EN
      4'd11: begin srca = 1; srcb = 2'b10; end
      4'd12: begin rw = 1; end
`endif
      default: ;
    endcase
    return {pcw, pcwc, pcw | (pcwc & z), pcs, iord, mr, mw, irw, m2r, rd, rw,
            aop, srca, srcb, ill};
  endfunction

  function automatic logic retires(input logic [3:0] s);
    return s == 4'd5 || s == 4'd6 || s == 4'd8 || s == 4'd9 || s == 4'd10
`ifdef ADDI_EN
           || s == 4'd12
`endif
           ;
  endfunction

  // Push the expectation for the coming cycle, then compare at the negedge.
  task automatic cycle(input logic [3:0] s);
    exp_t e;
    e.st   = s;
    e.ctrl = exp_ctrl(s, op, zero);
    if (!rst_n) m_cnt = 32'd0;
    e.cnt  = m_cnt;
    sb.push_back(e);
    if (rst_n && retires(s)) m_cnt = m_cnt + 32'd1;
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    check_eq($sformatf("state@%0d", cyc), {28'd0, state}, {28'd0, e.st});
    check_eq($sformatf("ctrl@%0d", cyc), {14'd0, obs_ctrl}, {14'd0, e.ctrl});
    check_eq($sformatf("cnt@%0d", cyc), instr_cnt, e.cnt);
  endtask

  // seq holds the state sequence one nibble per cycle, FETCH in nibble 0.
  task automatic do_instr(input logic [5:0] o, input logic z, input int n, input logic [23:0] seq);
    cycle(seq[3:0]);
    op   = o;
    zero = z;
    for (int i = 1; i < n; i++) cycle(seq[4*i +: 4]);
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 6'd0;
    zero  = 1'b0;
    m_cnt = 32'd0;
    cycle(4'd0);
    cycle(4'd0);
    rst_n = 1'b1;

    do_instr(6'b100011, 1'b0, 5, 24'h054321);   // lw
    do_instr(6'b000100, 1'b1, 3, 24'h000921);   // beq taken
    do_instr(6'b000100, 1'b0, 3, 24'h000921);   // beq not taken
    do_instr(6'b000000, 1'b0, 4, 24'h008721);   // R-type
    do_instr(6'b000010, 1'b1, 3, 24'h000A21);   // j
    do_instr(6'b101011, 1'b0, 4, 24'h006321);   // sw
    do_instr(6'b111111, 1'b0, 2, 24'h000021);   // illegal
`ifdef ADDI_EN
    do_instr(6'b001000, 1'b0, 4, 24'h00CB21);   // addi
`else
    do_instr(6'b001000, 1'b0, 2, 24'h000021);   // addi is illegal here
`endif

    // Reset in the middle of a load: no write-back, counter cleared.
    do_instr(6'b100011, 1'b0, 4, 24'h004321);
    rst_n = 1'b0;
    cycle(4'd0);
    rst_n = 1'b1;

    // Counter wrap: preset to all-ones during the final sw state.
    do_instr(6'b101011, 1'b0, 4, 24'h006321);
    #1 force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 check_eq("cnt_preset", instr_cnt, 32'hFFFF_FFFF);
    m_cnt = 32'd0;
    do_instr(6'b000010, 1'b0, 3, 24'h000A21);
    cycle(4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
